// File: rtl/gb_ram_arbiter.sv
// Two-port req/ack arbiter sharing one synchronous single-port RAM.
// Accesses are serialised IDLE -> ISSUE -> RESP, so there is one access every 3 cycles.
module gb_ram_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int P1_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state, state_n;
  logic                last_grant, last_n;
  logic                op_we, op_we_n;
  logic                ram_en_n, ram_we_n, busy_n, p0_ack_n, p1_ack_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n, p0_rdata_n, p1_rdata_n;
  logic [1:0]          grant_n;
  logic                p0_elig, p1_elig, win;

  // A port whose ack is high this cycle has not yet had a chance to drop req.
  assign p0_elig = p0_req & ~p0_ack;
  assign p1_elig = p1_req & ~p1_ack;
  assign win = (p0_elig & p1_elig) ? ((P1_PRIORITY != 0) ? 1'b1 : ~last_grant) : p1_elig;

  always_comb begin
    state_n    = state;
    last_n     = last_grant;
    op_we_n    = op_we;
    ram_en_n   = ram_en;
    ram_we_n   = ram_we;
    addr_n     = ram_addr;
    wdata_n    = ram_wdata;
    grant_n    = grant;
    busy_n     = busy;
    p0_ack_n   = 1'b0;
    p1_ack_n   = 1'b0;
    p0_rdata_n = p0_rdata;
    p1_rdata_n = p1_rdata;
    case (state)
      IDLE: begin
        if (p0_elig | p1_elig) begin
          state_n  = ISSUE;
          ram_en_n = 1'b1;
          ram_we_n = win ? p1_we : p0_we;
          op_we_n  = win ? p1_we : p0_we;
          addr_n   = win ? p1_addr : p0_addr;
          wdata_n  = win ? p1_wdata : p0_wdata;
          grant_n  = win ? 2'b10 : 2'b01;
          last_n   = win;
          busy_n   = 1'b1;
        end
      end
      ISSUE: begin
        ram_en_n = 1'b0;
        ram_we_n = 1'b0;
        state_n  = RESP;
      end
      RESP: begin
        // last_grant still names the port being served here.
        if (!op_we) begin
          if (last_grant) p1_rdata_n = ram_rdata;
          else            p0_rdata_n = ram_rdata;
        end
        p0_ack_n = ~last_grant;
        p1_ack_n = last_grant;
        grant_n  = 2'b00;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_we      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_n;
      op_we      <= op_we_n;
      ram_en     <= ram_en_n;
      ram_we     <= ram_we_n;
      ram_addr   <= addr_n;
      ram_wdata  <= wdata_n;
      grant      <= grant_n;
      busy       <= busy_n;
      p0_ack     <= p0_ack_n;
      p1_ack     <= p1_ack_n;
      p0_rdata   <= p0_rdata_n;
      p1_rdata   <= p1_rdata_n;
    end
  end

endmodule

// File: tb/tb_gb_ram_arbiter.sv
// Directed bench: a round-robin arbiter (a_*) and a port-1-priority arbiter (b_*) share stimulus,
// and each one has its own behavioural RAM.
module tb_gb_ram_arbiter;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [12:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;

  logic [7:0]  a_p0_rdata, a_p1_rdata, a_ram_wdata, a_ram_rdata = '0;
  logic        a_p0_ack, a_p1_ack, a_ram_en, a_ram_we, a_busy;
  logic [12:0] a_ram_addr;
  logic [1:0]  a_grant;
  logic [7:0]  b_p0_rdata, b_p1_rdata, b_ram_wdata, b_ram_rdata = '0;
  logic        b_p0_ack, b_p1_ack, b_ram_en, b_ram_we, b_busy;
  logic [12:0] b_ram_addr;
  logic [1:0]  b_grant;

  logic [7:0] mem_a [0:8191];
  logic [7:0] mem_b [0:8191];
  int total = 0, bad = 0;

  always #5 clock = ~clock;

  gb_ram_arbiter #(.ADDR_W(13), .DATA_W(8), .P1_PRIORITY(0)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(a_p0_rdata), .p0_ack(a_p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(a_p1_rdata), .p1_ack(a_p1_ack),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
    .ram_rdata(a_ram_rdata), .grant(a_grant), .busy(a_busy));

  gb_ram_arbiter #(.ADDR_W(13), .DATA_W(8), .P1_PRIORITY(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(b_p0_rdata), .p0_ack(b_p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(b_p1_rdata), .p1_ack(b_p1_ack),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
    .ram_rdata(b_ram_rdata), .grant(b_grant), .busy(b_busy));

  always @(posedge clock) begin
    if (a_ram_en) begin
      if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
      a_ram_rdata <= mem_a[a_ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      b_ram_rdata <= mem_b[b_ram_addr];
    end
  end

  // One cycle: inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic write_p1(input logic [12:0] addr, input logic [7:0] data);
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = addr; p1_wdata = data;
    tick(); tick(); tick();
    p1_req = 1'b0; p1_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; #2;
    total++; if ({a_ram_en, a_ram_we, a_grant, a_busy, a_p0_ack, a_p1_ack} !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=0", {a_ram_en, a_ram_we, a_grant, a_busy, a_p0_ack, a_p1_ack}); end
    total++; if ({a_ram_addr, a_ram_wdata, a_p0_rdata, a_p1_rdata} !== 37'b0) begin bad++; $display("FAIL reset_data got=%h exp=0", {a_ram_addr, a_ram_wdata, a_p0_rdata, a_p1_rdata}); end
    do_reset();
    total++; if ({a_busy, a_grant, a_ram_en} !== 4'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", {a_busy, a_grant, a_ram_en}); end
  endtask

  task automatic test_write();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 13'h0123; p0_wdata = 8'hA5;
    tick();
    total++; if ({a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata} !== {1'b1, 1'b1, 13'h0123, 8'hA5}) begin bad++; $display("FAIL wr_issue got=%b %b %h %h exp=1 1 0123 a5", a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata); end
    total++; if ({a_grant, a_busy} !== 3'b011) begin bad++; $display("FAIL wr_grant got=%b exp=011", {a_grant, a_busy}); end
    tick();
    total++; if ({a_ram_en, a_ram_we, a_p0_ack} !== 3'b000) begin bad++; $display("FAIL wr_resp got=%b exp=000", {a_ram_en, a_ram_we, a_p0_ack}); end
    tick();
    total++; if ({a_p0_ack, a_p1_ack, a_grant} !== 4'b1000) begin bad++; $display("FAIL wr_ack got=%b exp=1000", {a_p0_ack, a_p1_ack, a_grant}); end
    total++; if (a_p0_rdata !== 8'h00) begin bad++; $display("FAIL wr_rdata got=%h exp=00", a_p0_rdata); end
    p0_req = 1'b0; p0_we = 1'b0;
    tick();
    total++; if ({a_p0_ack, a_busy} !== 2'b00) begin bad++; $display("FAIL wr_ack_pulse got=%b exp=00", {a_p0_ack, a_busy}); end
  endtask

  task automatic test_read_p1();
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 13'h0123;
    tick();
    total++; if ({a_grant, a_ram_en, a_ram_we} !== 4'b1010) begin bad++; $display("FAIL rd_issue got=%b exp=1010", {a_grant, a_ram_en, a_ram_we}); end
    tick();
    total++; if (a_p1_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%b exp=0", a_p1_ack); end
    tick();
    total++; if ({a_p1_ack, a_p0_ack} !== 2'b10) begin bad++; $display("FAIL rd_ack got=%b exp=10", {a_p1_ack, a_p0_ack}); end
    total++; if (a_p1_rdata !== 8'hA5) begin bad++; $display("FAIL rd_data got=%h exp=a5", a_p1_rdata); end
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_contend();
    logic [1:0] exp_g [1:6];
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    write_p1(13'h0010, 8'h3C);
    write_p1(13'h1FFF, 8'hC3);
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 13'h1FFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      total++; if (a_grant !== exp_g[c]) begin bad++; $display("FAIL contend_grant c=%0d got=%b exp=%b", c, a_grant, exp_g[c]); end
      if (c == 3) begin
        total++; if ({a_p0_ack, a_p1_ack, a_p0_rdata} !== {2'b10, 8'h3C}) begin bad++; $display("FAIL contend_p0 got=%b%b %h exp=10 3c", a_p0_ack, a_p1_ack, a_p0_rdata); end
        p0_req = 1'b0;
      end
      if (c == 6) begin
        total++; if ({a_p0_ack, a_p1_ack, a_p1_rdata} !== {2'b01, 8'hC3}) begin bad++; $display("FAIL contend_p1 got=%b%b %h exp=01 c3", a_p0_ack, a_p1_ack, a_p1_rdata); end
        p1_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [1:0] ea;
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 13'h1FFF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      eg = ((c - 1) % 3 == 2) ? 2'b00 : ((((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10);
      ea = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b01 : 2'b10);
      total++; if ({a_grant, a_p1_ack, a_p0_ack} !== {eg, ea}) begin bad++; $display("FAIL rr c=%0d got=%b exp=%b", c, {a_grant, a_p1_ack, a_p0_ack}, {eg, ea}); end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_priority();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 13'h1FFF;
    tick();
    total++; if ({b_grant, a_grant} !== 4'b1001) begin bad++; $display("FAIL prio_tie got=%b exp=1001", {b_grant, a_grant}); end
    tick(); tick();
    total++; if ({b_p1_ack, b_p0_ack, b_p1_rdata} !== {2'b10, 8'hC3}) begin bad++; $display("FAIL prio_p1 got=%b%b %h exp=10 c3", b_p1_ack, b_p0_ack, b_p1_rdata); end
    p1_req = 1'b0;
    tick();
    total++; if (b_grant !== 2'b01) begin bad++; $display("FAIL prio_p0_grant got=%b exp=01", b_grant); end
    tick(); tick();
    total++; if ({b_p0_ack, b_p1_ack, b_p0_rdata} !== {2'b10, 8'h3C}) begin bad++; $display("FAIL prio_p0 got=%b%b %h exp=10 3c", b_p0_ack, b_p1_ack, b_p0_rdata); end
    p0_req = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 13'h1FFF;
    tick();
    total++; if ({a_ram_en, a_grant} !== 3'b101) begin bad++; $display("FAIL mid_issue got=%b exp=101", {a_ram_en, a_grant}); end
    reset_n = 1'b0; #1;
    total++; if ({a_ram_en, a_grant, a_busy} !== 4'b0) begin bad++; $display("FAIL mid_abort got=%b exp=0", {a_ram_en, a_grant, a_busy}); end
    p0_req = 1'b0;
    tick(); reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({a_p0_ack, a_busy} !== 2'b00) begin bad++; $display("FAIL mid_no_ack c=%0d got=%b exp=00", c, {a_p0_ack, a_busy}); end
    end
    p0_req = 1'b1; p0_addr = 13'h0010;
    tick(); tick();
    total++; if (a_p0_ack !== 1'b0) begin bad++; $display("FAIL mid_early_ack got=%b exp=0", a_p0_ack); end
    tick();
    total++; if ({a_p0_ack, a_p0_rdata} !== {1'b1, 8'h3C}) begin bad++; $display("FAIL mid_reread got=%b %h exp=1 3c", a_p0_ack, a_p0_rdata); end
    p0_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_p1();
    test_contend();
    test_round_robin();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
